// File: rtl/ascii_pkg.sv
// Shared definitions for the keyboard-path ASCII blocks.
// Holds the ASCII code points used by the hex digit decoder and the
// parser state type.
package ascii_pkg;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_F_UC = 8'h46;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_F_LC = 8'h66;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_SP   = 8'h20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } parser_state_e;

endpackage

// File: rtl/ascii_hex_digit.sv
// Combinational ASCII character classifier.
//   in_data_i  : ASCII character
//   is_digit_o : character is 0-9, A-F or a-f
//   is_term_o  : character is CR or space
//   nibble_o   : binary value of the digit (0 when not a digit)
module ascii_hex_digit
  import ascii_pkg::*;
(
  input  logic [7:0] in_data_i,
  output logic       is_digit_o,
  output logic       is_term_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_digit_o = 1'b0;
    is_term_o  = 1'b0;
    nibble_o   = 4'd0;
    if (in_data_i >= ASCII_0 && in_data_i <= ASCII_9) begin
      is_digit_o = 1'b1;
      nibble_o   = 4'(in_data_i - ASCII_0);
    end else if (in_data_i >= ASCII_A_UC && in_data_i <= ASCII_F_UC) begin
      is_digit_o = 1'b1;
      nibble_o   = 4'(in_data_i - ASCII_A_UC) + 4'd10;
    end else if (in_data_i >= ASCII_A_LC && in_data_i <= ASCII_F_LC) begin
      is_digit_o = 1'b1;
      nibble_o   = 4'(in_data_i - ASCII_A_LC) + 4'd10;
    end else if (in_data_i == ASCII_CR || in_data_i == ASCII_SP) begin
      is_term_o  = 1'b1;
    end
  end

endmodule

// File: rtl/ascii_hex_parser.sv
// Streaming ASCII-hex to binary parser.
// Collects hex digits MSB-first into a word of 8*NBYTES bits. A word is
// emitted when NDIGITS digits have arrived, or earlier on CR/space
// (right-aligned, zero-extended). Illegal characters pulse err_o and
// discard the partial word.
//   clk_i, rst_ni            : clock, async active-low reset
//   in_valid_i/in_ready_o    : input byte handshake, in_data_i the byte
//   out_valid_o/out_ready_i  : output word handshake, out_data_o the word
//   err_o                    : one-cycle pulse on an illegal byte
//   digit_cnt_o              : digits held in the current word
//
// state   | meaning
// IDLE    | no partial word held, digit count zero
// COLLECT | 1 to NDIGITS-1 digits held
// HOLD    | completed word presented, waiting for out_ready_i
module ascii_hex_parser
  import ascii_pkg::*;
#(
  parameter int NBYTES  = 2,
  localparam int NDIGITS = 2 * NBYTES,
  localparam int W       = 8 * NBYTES,
  localparam int CW      = $clog2(NDIGITS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [7:0]    in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  out_data_o,
  output logic          err_o,
  output logic [CW-1:0] digit_cnt_o
);

  parser_state_e state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          is_digit, is_term;
  logic [3:0]    nibble;
  logic          accept;
  logic [W-1:0]  acc_shift;

  ascii_hex_digit u_digit (
    .in_data_i  (in_data_i),
    .is_digit_o (is_digit),
    .is_term_o  (is_term),
    .nibble_o   (nibble)
  );

  assign in_ready_o  = (state_q != HOLD);
  assign out_valid_o = (state_q == HOLD);
  assign out_data_o  = out_q;
  assign err_o       = err_q;
  assign digit_cnt_o = cnt_q;

  assign accept    = in_valid_i && in_ready_o;
  assign acc_shift = {acc_q[W-5:0], nibble};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          if (is_digit) begin
            acc_d = acc_shift;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NDIGITS - 1)) begin
              out_d   = acc_shift;
              state_d = HOLD;
            end else begin
              state_d = COLLECT;
            end
          end else if (is_term) begin
            // The accumulator starts at zero, so it is already right-aligned.
            if (state_q == COLLECT) begin
              out_d   = acc_q;
              state_d = HOLD;
            end
          end else begin
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/ascii_hex_parser.md
# ascii_hex_parser

Streaming parser that converts ASCII hexadecimal characters back into a binary word: the inverse of the keyboard path's binary-to-ASCII converter. Sits between the keyboard/UART byte stream and register-write logic. Accepts one byte per handshake, accumulates hex digits MSB-first, and emits a packed binary word on a valid/ready output. Reports malformed input with an error pulse.

## Interface
- NBYTES, 2: output word size in bytes. Digits per word NDIGITS = 2*NBYTES; output width W = 8*NBYTES.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  parser can accept a byte.
- in_data  in  8  ASCII character.
- out_valid  out  1  out_data holds a completed word.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  W  parsed binary word.
- err  out  1  one-cycle pulse on an illegal character.
- digit_cnt  out  $clog2(NDIGITS+1)  digits held in the current partial word.

## Operation
- Character classes, decoded combinationally from in_data:
  - DIGIT: '0'-'9' (0x30-0x39) maps to 0-9; 'A'-'F' (0x41-0x46) and 'a'-'f' (0x61-0x66) map to 10-15.
  - TERM: CR (0x0D) or space (0x20).
  - ILLEGAL: every other value.
- Accept event: in_valid && in_ready.
- States:
  - IDLE: no partial word held; digit_cnt = 0.
  - COLLECT: 1 to NDIGITS-1 digits held.
  - HOLD: out_valid = 1, waiting for the consumer.
- Accumulator acc[W-1:0] is cleared on entry to IDLE. Each DIGIT updates acc <= {acc[W-5:0], nibble} and increments digit_cnt.
- DIGIT in IDLE or COLLECT:
  - If this is digit number NDIGITS, out_data <= the updated acc; go to HOLD.
  - Otherwise go to (or stay in) COLLECT.
- TERM in COLLECT: flush the partial word right-aligned and zero-extended (e.g. "AB" then CR gives 0x00AB); go to HOLD.
- TERM in IDLE: ignored, no output, no err.
- ILLEGAL in any accepting state: err pulses for one cycle, the partial word is discarded, go to IDLE.
- HOLD:
  - in_ready = 0.
  - When out_valid && out_ready, return to IDLE; acc and digit_cnt are zeroed.
- in_ready = (state != HOLD). It is combinational from state only and never depends on in_valid.
- out_data is stable while out_valid = 1 and retains its last value after the pop.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, err = 0, digit_cnt = 0, state = IDLE.
- Latency:
  - out_valid rises on the clock edge that accepts the final digit or the TERM, i.e. one cycle after the byte is presented.
  - err rises on the clock edge that accepts the ILLEGAL byte and is high for exactly one cycle.
- Throughput: one byte per cycle while collecting. Each completed word costs at least one extra cycle in HOLD, because the pop and in_ready returning high are on consecutive cycles.
- Simultaneous pop and new byte: impossible by construction, since in_ready = 0 in HOLD. A byte offered during HOLD is not consumed.
- Back-pressure: out_valid stays high for any number of cycles until out_ready; there is no timeout.
- Reset mid-operation: asynchronously returns to IDLE. The partial word is lost and out_valid drops immediately; no err is generated.
- NBYTES = 1: a word is two digits. All width rules scale with W.

## Structure
- Shared package ascii_pkg holds:
  - ASCII constants: ASCII_0, ASCII_9, ASCII_A_UC, ASCII_F_UC, ASCII_A_LC, ASCII_F_LC, ASCII_CR, ASCII_SP.
  - The state type: enum IDLE/COLLECT/HOLD.
- Sub-module ascii_hex_digit (combinational) takes in_data[7:0] and outputs is_digit, is_term, nibble[3:0]. It is reusable by other keyboard-path blocks.
- Top level: one state register, accumulator, digit counter, output register.

## Test plan
- "1A3F" at one byte per cycle with out_ready = 1 -> out_valid for one cycle, out_data = 0x1A3F, err = 0.
- "ab" then CR -> out_data = 0x00AB. Then "7" then space -> out_data = 0x0007.
- "12" then 'G' (0x47) -> err pulse for one cycle, no output. Then "0001" -> out_data = 0x0001.
- "BEEF" with out_ready = 0 for 10 cycles -> out_valid held, in_ready = 0, and a pending '5' is not consumed. After out_ready pulses, '5' is accepted and digit_cnt = 1.
- CR, space and CR in IDLE -> no out_valid, no err, digit_cnt stays 0.
- "C0" then rst_n low mid-word, then "0000" -> outputs at reset values during reset, then out_data = 0x0000 with no residue from "C0".
